// File: rtl/frame_mem_pkg.sv
// Shared constants and types for the ZBT frame-buffer arbiter.
// Frame geometry, pixel-address widths and the per-access pipeline tag live here.
package frame_mem_pkg;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 36;
  localparam int ZBT_LAT    = 2;
  localparam int IDX_W      = 2;

  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  localparam logic [9:0] CHROMA_NEUTRAL = 10'd512;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
  } stage_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [Y_W-1:0] y,
                                                 input logic [X_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the pointer is bit 0,
// isolate the lowest set bit, rotate the one-hot result back.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] req_rot;
  logic [N-1:0] pick_rot;

  always_comb begin
    req_rot  = N'({req, req} >> ptr);
    pick_rot = req_rot & (~req_rot + N'(1));
    grant    = N'(({pick_rot, pick_rot} << ptr) >> N);
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port ZBT frame-buffer arbiter with in-order read return.
// Optional macro FRAME_MEM_DISPLAY_PRIORITY_EN gives requester 0 absolute priority.
module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wdata_oe,
  input  logic [DATA_W-1:0]         mem_rdata
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] grant;
  logic               granted;
  logic               ptr_adv;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  stage_t             new_stage;
  stage_t             stage [ZBT_LAT+1];

`ifdef FRAME_MEM_DISPLAY_PRIORITY_EN
  assign pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(.N(NUM_REQ), .PTR_W(IDX_W)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (pick_grant)
  );

  always_comb begin
    grant = pick_grant;
`ifdef FRAME_MEM_DISPLAY_PRIORITY_EN
    if (req_valid[0]) grant = NUM_REQ'(1);
`endif
    if (reset) grant = '0;
  end

  assign req_ready = grant;
  assign granted   = |grant;

`ifdef FRAME_MEM_DISPLAY_PRIORITY_EN
  assign ptr_adv = granted && !grant[0];
`else
  assign ptr_adv = granted;
`endif

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_we    = req_we[i];
      end
    end
    new_stage.valid = granted;
    new_stage.we    = sel_we;
    new_stage.idx   = grant_idx;
    new_stage.wdata = sel_we ? sel_wdata : '0;
  end

  // Tag stage k describes the access whose address phase was k cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      rd_valid <= '0;
      rd_data  <= '0;
      for (int k = 0; k <= ZBT_LAT; k++) stage[k] <= '0;
    end else begin
      if (ptr_adv)
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      if (granted) mem_addr <= sel_addr;
      mem_we   <= granted & sel_we;
      stage[0] <= new_stage;
      for (int k = 1; k <= ZBT_LAT; k++) stage[k] <= stage[k-1];
      rd_valid <= '0;
      if (stage[ZBT_LAT].valid && !stage[ZBT_LAT].we) begin
        rd_valid <= NUM_REQ'(1) << stage[ZBT_LAT].idx;
        rd_data  <= mem_rdata;
      end
    end
  end

  assign mem_wdata    = stage[ZBT_LAT].wdata;
  assign mem_wdata_oe = stage[ZBT_LAT].valid & stage[ZBT_LAT].we;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: ZBT pin model, reference arbiter
// and a behavioural memory/scoreboard, plus directed and random scenarios.
`timescale 1ns/1ps
module tb_frame_mem_arbiter;
  import frame_mem_pkg::*;

  localparam int N   = 3;
  localparam int LAT = ZBT_LAT + 2;
`ifdef FRAME_MEM_DISPLAY_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_we = '0;
  logic [N*ADDR_W-1:0]   req_addr = '0;
  logic [N*DATA_W-1:0]   req_wdata = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_wdata_oe;
  logic [DATA_W-1:0]     mem_rdata = '0;

  frame_mem_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } txn_t;
  typedef struct { int idx; logic [DATA_W-1:0] data; int acc; } ret_t;

  txn_t txq [N][$];
  ret_t expq [$];
  logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] zbt_mem   [logic [ADDR_W-1:0]];
  int grant_log [$];
  int grant_cyc [$];
  int ret_cyc   [$];
  int rr_ptr_m = 0;

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return {a[16:0], a} ^ 36'h93C5A0F17;
  endfunction

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  // ZBT device: address phase in cycle c, data phase in cycle c+ZBT_LAT.
  logic [ADDR_W-1:0] h_addr [3];
  logic              h_we   [3];
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin h_addr[k] = '0; h_we[k] = 1'b0; end
    end else begin
      h_addr[2] = h_addr[1]; h_we[2] = h_we[1];
      h_addr[1] = h_addr[0]; h_we[1] = h_we[0];
      h_addr[0] = mem_addr;  h_we[0] = mem_we;
      checks++;
      if (mem_wdata_oe !== h_we[2]) begin
        errors++;
        $display("FAIL zbt_oe_phase: got oe=%b want %b at cycle %0d", mem_wdata_oe, h_we[2], cyc);
      end
      if (mem_wdata_oe === 1'b1) zbt_mem[h_addr[2]] = mem_wdata;
      mem_rdata = zbt_mem.exists(h_addr[2]) ? zbt_mem[h_addr[2]] : init_word(h_addr[2]);
    end
  end

  // Reference arbiter + scoreboard.
  logic [N-1:0] prev_valid = '0, prev_ready = '0, exp_g;
  logic         prev_reset = 1'b1;
  bit           found;
  int           jj;
  ret_t         e;
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL ready_in_reset: got %b want 000", req_ready);
      end
      expq.delete();
      rr_ptr_m = 0;
    end else begin
      if (rd_valid !== '0) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got rd_valid=%b want 000 at cycle %0d", rd_valid, cyc);
        end else begin
          e = expq.pop_front();
          if (rd_valid !== (N'(1) << e.idx) || rd_data !== e.data || cyc - e.acc != LAT) begin
            errors++;
            $display("FAIL rd_return: got valid=%b data=%h lat=%0d want valid=%b data=%h lat=%0d",
                     rd_valid, rd_data, cyc - e.acc, N'(1) << e.idx, e.data, LAT);
          end
          ret_cyc.push_back(cyc);
        end
      end
      exp_g = '0;
      found = 0;
      if (PRIO && req_valid[0]) begin exp_g[0] = 1'b1; found = 1; end
      for (int k = 0; k < N; k++) begin
        jj = (rr_ptr_m + k) % N;
        if (!found && req_valid[jj] && !(PRIO && jj == 0)) begin exp_g[jj] = 1'b1; found = 1; end
      end
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL grant: got %b want %b (valid=%b) at cycle %0d", req_ready, exp_g, req_valid, cyc);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
          if (!(PRIO && i == 0)) rr_ptr_m = (i + 1) % N;
          if (req_we[i]) model_mem[req_addr[i*ADDR_W +: ADDR_W]] = req_wdata[i*DATA_W +: DATA_W];
          else expq.push_back('{idx: i, data: model_rd(req_addr[i*ADDR_W +: ADDR_W]), acc: cyc});
        end
      end
      if (!prev_reset) begin
        checks++;
        if ((prev_valid & ~prev_ready & ~req_valid) !== '0) begin
          errors++;
          $display("FAIL valid_dropped: got valid=%b after unaccepted %b, want held", req_valid, prev_valid);
        end
      end
    end
    prev_valid = req_valid;
    prev_ready = req_ready;
    prev_reset = reset;
  end

  task automatic load_heads(input int gap_pct);
    txn_t t;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && txq[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        t = txq[i].pop_front();
        req_we[i] = t.we;
        req_addr[i*ADDR_W +: ADDR_W] = t.addr;
        req_wdata[i*DATA_W +: DATA_W] = t.wdata;
        req_valid[i] = 1'b1;
      end
    end
  endtask

  function automatic int pending();
    return txq[0].size() + txq[1].size() + txq[2].size();
  endfunction

  task automatic run_queues(input int budget, input int gap_pct, output int used);
    logic [N-1:0] acc;
    used = 0;
    @(posedge clk); #1;
    load_heads(gap_pct);
    while ((req_valid != '0 || pending() > 0) && used < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      load_heads(gap_pct);
      used++;
    end
    checks++;
    if (req_valid != '0 || pending() > 0) begin
      errors++;
      $display("FAIL run_timeout: got %0d txns pending after %0d cycles, want 0", pending(), budget);
      req_valid = '0;
      for (int i = 0; i < N; i++) txq[i].delete();
    end
  endtask

  task automatic drain_check(input string name);
    repeat (10) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d reads outstanding, want 0", name, expq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rd_valid !== '0 || mem_we !== 1'b0 || mem_wdata_oe !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdv=%b we=%b oe=%b addr=%h wd=%h rd=%h want all 0",
               rd_valid, mem_we, mem_wdata_oe, mem_addr, mem_wdata, rd_data);
    end
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1*ADDR_W +: ADDR_W] = 19'h00005;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL read_ready: got %b want 010", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_addr !== 19'h00005 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL read_addr_phase: got addr=%h we=%b want 00005 0", mem_addr, mem_we);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_valid !== 3'b010 || rd_data !== init_word(19'h00005)) begin
      errors++;
      $display("FAIL read_return: got valid=%b data=%h want 010 %h", rd_valid, rd_data, init_word(19'h00005));
    end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    req_valid[2] = 1'b1; req_we[2] = 1'b1;
    req_addr[2*ADDR_W +: ADDR_W] = 19'h7FFFF; req_wdata[2*DATA_W +: DATA_W] = 36'h123456789;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL write_ready: got %b want 100", req_ready); end
    @(posedge clk); #1;
    req_valid[2] = 1'b0; req_we[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 19'h7FFFF || mem_wdata_oe !== 1'b0) begin
      errors++;
      $display("FAIL write_addr_phase: got we=%b addr=%h oe=%b want 1 7ffff 0", mem_we, mem_addr, mem_wdata_oe);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_wdata_oe !== 1'b0) begin
      errors++;
      $display("FAIL write_gap: got we=%b oe=%b want 0 0", mem_we, mem_wdata_oe);
    end
    @(negedge clk);
    checks++;
    if (mem_wdata_oe !== 1'b1 || mem_wdata !== 36'h123456789) begin
      errors++;
      $display("FAIL write_data_phase: got oe=%b data=%h want 1 123456789", mem_wdata_oe, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (mem_wdata_oe !== 1'b0) begin errors++; $display("FAIL write_oe_single: got oe=%b want 0", mem_wdata_oe); end
  endtask

  task automatic test_round_robin();
    int used;
    int exp_rr [6];
    if (PRIO) exp_rr = '{0, 0, 1, 2, 1, 2};
    else      exp_rr = '{0, 1, 2, 0, 1, 2};
    grant_log.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        txq[i].push_back('{we: 1'b0, addr: ADDR_W'(32'h100 + i*16 + k), wdata: '0});
    run_queues(50, 0, used);
    checks++;
    if (grant_log.size() != 6) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 6", grant_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grant_log[k] != exp_rr[k]) begin
          errors++;
          $display("FAIL rr_order: grant %0d got req%0d want req%0d", k, grant_log[k], exp_rr[k]);
        end
      end
    end
    drain_check("rr");
  endtask

  task automatic test_back_to_back_raw();
    int used;
    bit seen;
    logic [DATA_W-1:0] got;
    grant_log.delete(); grant_cyc.delete();
    txq[1].push_back('{we: 1'b1, addr: 19'h00010, wdata: 36'h00000AAAA});
    txq[2].push_back('{we: 1'b0, addr: 19'h00010, wdata: '0});
    run_queues(20, 0, used);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 2 || grant_cyc[1] - grant_cyc[0] != 1) begin
      errors++;
      $display("FAIL raw_grants: got %0d grants (first req%0d) want req1 then req2 in adjacent cycles",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
    end
    seen = 0; got = '0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (rd_valid[2] === 1'b1) begin seen = 1; got = rd_data; end
    end
    checks++;
    if (!seen || got !== 36'h00000AAAA) begin
      errors++;
      $display("FAIL raw_data: got seen=%0d data=%h want 1 00000aaaa", seen, got);
    end
    drain_check("raw");
  endtask

  task automatic test_reset_flush();
    int used;
    txq[0].push_back('{we: 1'b0, addr: 19'h00020, wdata: '0});
    txq[1].push_back('{we: 1'b0, addr: 19'h00021, wdata: '0});
    txq[1].push_back('{we: 1'b0, addr: 19'h00022, wdata: '0});
    run_queues(20, 0, used);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== '0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet: got rd_valid=%b mem_we=%b want 000 0", rd_valid, mem_we);
      end
    end
    grant_log.delete();
    for (int i = 0; i < N; i++) txq[i].push_back('{we: 1'b0, addr: ADDR_W'(32'h30 + i), wdata: '0});
    run_queues(20, 0, used);
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL flush_ptr: got first grant req%0d want req0", grant_log.size() > 0 ? grant_log[0] : -1);
    end
    drain_check("flush");
  endtask

  task automatic test_stream();
    int used;
    grant_log.delete(); grant_cyc.delete(); ret_cyc.delete();
    for (int a = 0; a < IMG_WIDTH; a++) txq[1].push_back('{we: 1'b0, addr: ADDR_W'(a), wdata: '0});
    run_queues(700, 0, used);
    checks++;
    if (used != IMG_WIDTH || grant_cyc.size() != IMG_WIDTH ||
        grant_cyc[grant_cyc.size()-1] - grant_cyc[0] != IMG_WIDTH - 1) begin
      errors++;
      $display("FAIL stream_grants: got %0d grants in %0d cycles want 640 in 640", grant_cyc.size(), used);
    end
    drain_check("stream");
    checks++;
    if (ret_cyc.size() != IMG_WIDTH || grant_cyc.size() == 0 ||
        ret_cyc[0] - grant_cyc[0] != LAT || ret_cyc[ret_cyc.size()-1] - ret_cyc[0] != IMG_WIDTH - 1) begin
      errors++;
      $display("FAIL stream_returns: got %0d returns want 640 contiguous starting %0d after first grant",
               ret_cyc.size(), LAT);
    end
  endtask

  task automatic test_random(input int gap_pct);
    int used;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 80; k++)
        txq[i].push_back('{we: 1'($urandom_range(1)),
                           addr: ADDR_W'(32'h300 + $urandom_range(15)),
                           wdata: DATA_W'({$urandom(), $urandom()})});
    run_queues(3000, gap_pct, used);
    drain_check("random");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_back_to_back_raw();
    test_reset_flush();
    test_stream();
    test_random(0);
    test_random(40);
    test_random(75);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2ms want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Shares the single 36-bit ZBT frame-buffer port between NUM_REQ pixel engines: the Gaussian blur reader, the blur writer, and the VGA display fetch.
- Grants at most one access per clock. Drives the ZBT address, write-enable and delayed write-data pipeline.
- Routes read data back to the requester that issued the read, in order, after the fixed ZBT latency.
- Sits between the processing engines and the ZBT pin driver.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = display fetch).
- ADDR_W, 19, word address width ({y[8:0], x[9:0]}).
- DATA_W, 36, memory word width.
- ZBT_LAT, 2, cycles from address phase to data phase (read data in, write data out).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_ready  out  NUM_REQ  one-hot grant; access accepted when valid & ready
- rd_valid  out  NUM_REQ  one-hot read return strobe
- rd_data  out  DATA_W  read return data, shared by all requesters
- mem_addr  out  ADDR_W  ZBT address
- mem_we  out  1  ZBT write enable, active-high
- mem_wdata  out  DATA_W  ZBT write data
- mem_wdata_oe  out  1  tristate enable for the data bus
- mem_rdata  in  DATA_W  ZBT read data

Behaviour:
- Reset values: req_ready (registered portion), rd_valid, mem_we and mem_wdata_oe all 0; mem_addr, mem_wdata and rd_data all 0.
- Reset state: RR pointer = 0; all in-flight pipeline stages cleared. Reset mid-operation discards outstanding reads; no rd_valid ever fires for them.
- Grant:
  - req_ready is combinational from req_valid and the RR pointer.
  - Exactly zero or one bit is set.
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - After a grant to i, pointer <= (i+1) mod NUM_REQ. Pointer is unchanged when nothing is granted.
  - req_ready is forced to 0 while reset is high.
- Requester rule: once req_valid is raised, req_we, req_addr and req_wdata hold stable until accepted. Dropping req_valid before acceptance is illegal; the bench flags it.
- Pipeline (acceptance in cycle t):
  - t+1: mem_addr = addr; mem_we = we.
  - t+1+ZBT_LAT: for writes, mem_wdata = wdata and mem_wdata_oe = 1 for that single cycle.
  - t+1+ZBT_LAT: for reads, mem_rdata is sampled.
  - t+2+ZBT_LAT: for reads, rd_data = sampled word and rd_valid[i] = 1 for one cycle. Total read latency is 4 cycles at default.
- Idle cycle: mem_we = 0; mem_addr holds its last value; mem_wdata_oe = 0 unless a prior write's data phase lands in that cycle.
- Tag pipeline: ZBT_LAT+1 stages, each holding {valid, we, requester index, wdata}. Fully pipelined: back-to-back accesses every cycle, including read→write and write→read turnarounds (ZBT needs no dead cycle).
- Ordering: returns are in acceptance order. A read after a write to the same address by any requester returns the new data.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,0,…
  - A single persistent requester is granted every cycle.

Optional Feature:
- Macro: FRAME_MEM_DISPLAY_PRIORITY_EN.
- Defined: requester 0 wins whenever req_valid[0] = 1, regardless of the pointer. The pointer updates only on grants to requesters 1..NUM_REQ-1, round-robin among those only.
- Not defined: pure round-robin over all requesters, as above.

Decomposition:
- Package frame_mem_pkg holds:
  - ADDR_W, DATA_W, ZBT_LAT.
  - IMG_WIDTH = 640, IMG_HEIGHT = 480.
  - Pixel-address helper constant widths (X_W = 10, Y_W = 9).
  - The YCrCb neutral chroma constant 512.
  - The pipeline-stage struct/typedef {valid, we, idx, wdata}.
- One sub-module is natural: rr_pick. It is a combinational rotate-priority-rotate one-hot picker taking request vector and pointer, producing a one-hot grant.

Test Plan:
- Reset, then req1 read addr 0x00005: req_ready=3'b010 same cycle; mem_addr=0x00005, mem_we=0 next cycle; rd_valid=3'b010 with rd_data equal to the model word 4 cycles after acceptance.
- req2 writes 0x123456789 to 0x7FFFF at t: mem_we=1 at t+1; mem_wdata=0x123456789 with mem_wdata_oe=1 at t+3 only.
- req0, req1, req2 held valid (reads) for 6 cycles: grants 0,1,2,0,1,2; returns in the same order with per-address data. With FRAME_MEM_DISPLAY_PRIORITY_EN: grants 0,0,0,… while req0 stays valid.
- req1 write 0xAAAA to 0x10 then req2 read 0x10 in consecutive cycles: req2 rd_data = 0xAAAA; no idle cycle inserted.
- Three reads accepted, reset pulsed 1 cycle later: no rd_valid asserted afterwards; mem_we=0 and the pointer back at 0 (next simultaneous request granted to req0).
- req1 streams 640 reads to addresses 0..639 continuously: 640 grants in 640 cycles, then rd_valid high for 640 consecutive cycles starting 4 cycles after the first grant.
